// File: rtl/scoreboard.sv
// Register-status scoreboard for a 32-entry register file.
// Each entry tracks a pending result, its producing unit and a one-hot countdown row.
module scoreboard #(
    parameter int unsigned LAT_U0 = 1,
    parameter int unsigned LAT_U1 = 3,
    parameter int unsigned LAT_U2 = 4,
    parameter int unsigned LAT_U3 = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] ass_addr_a,
    output logic       ass_pending_a,
    output logic [1:0] ass_unit_a,
    output logic [4:0] ass_row_a,
    input  logic [4:0] ass_addr_b,
    output logic       ass_pending_b,
    output logic [1:0] ass_unit_b,
    output logic [4:0] ass_row_b,
    input  logic [1:0] registerunit,
    input  logic [4:0] writeaddr,
    input  logic       enablewrite
);

    // One-hot row loaded on issue: writeback happens LAT cycles after the issue edge.
    function automatic logic [4:0] row_for_unit(input logic [1:0] unit);
        logic [4:0] row;
        case (unit)
            2'd0:    row = 5'd1 << (LAT_U0 - 1);
            2'd1:    row = 5'd1 << (LAT_U1 - 1);
            2'd2:    row = 5'd1 << (LAT_U2 - 1);
            2'd3:    row = 5'd1 << (LAT_U3 - 1);
            default: row = 5'd0;
        endcase
        return row;
    endfunction

    logic [31:0]      pending_q, pending_d;
    logic [31:0][1:0] unit_q, unit_d;
    logic [31:0][4:0] row_q, row_d;

    // Next-state: issue wins over countdown; entry 0 is hardwired to zero.
    always_comb begin
        pending_d = pending_q;
        unit_d    = unit_q;
        row_d     = row_q;
        pending_d[0] = 1'b0;
        unit_d[0]    = 2'd0;
        row_d[0]     = 5'd0;
        for (int i = 1; i < 32; i++) begin
            if (enablewrite && (writeaddr == 5'(i))) begin
                pending_d[i] = 1'b1;
                unit_d[i]    = registerunit;
                row_d[i]     = row_for_unit(registerunit);
            end else if (row_q[i] == 5'b00001) begin
                pending_d[i] = 1'b0;
                unit_d[i]    = 2'd0;
                row_d[i]     = 5'd0;
            end else if (pending_q[i]) begin
                row_d[i] = row_q[i] >> 1;
            end else begin
                pending_d[i] = 1'b0;
                unit_d[i]    = 2'd0;
                row_d[i]     = 5'd0;
            end
        end
    end

    // State register with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
            unit_q    <= '0;
            row_q     <= '0;
        end else begin
            pending_q <= pending_d;
            unit_q    <= unit_d;
            row_q     <= row_d;
        end
    end

    // Combinational read ports, no write bypass.
    always_comb begin
        ass_pending_a = pending_q[ass_addr_a];
        ass_unit_a    = unit_q[ass_addr_a];
        ass_row_a     = row_q[ass_addr_a];
        ass_pending_b = pending_q[ass_addr_b];
        ass_unit_b    = unit_q[ass_addr_b];
        ass_row_b     = row_q[ass_addr_b];
    end

endmodule

// File: tb/tb_scoreboard.sv
// Directed self-checking bench for the scoreboard; entries are compared as {pending, unit, row}.
module tb_scoreboard;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] ass_addr_a, ass_addr_b;
    logic       ass_pending_a, ass_pending_b;
    logic [1:0] ass_unit_a, ass_unit_b;
    logic [4:0] ass_row_a, ass_row_b;
    logic [1:0] registerunit;
    logic [4:0] writeaddr;
    logic       enablewrite;

    int check_cnt = 0;
    int error_cnt = 0;

    scoreboard dut (
        .clock         (clock),
        .reset         (reset),
        .ass_addr_a    (ass_addr_a),
        .ass_pending_a (ass_pending_a),
        .ass_unit_a    (ass_unit_a),
        .ass_row_a     (ass_row_a),
        .ass_addr_b    (ass_addr_b),
        .ass_pending_b (ass_pending_b),
        .ass_unit_b    (ass_unit_b),
        .ass_row_b     (ass_row_b),
        .registerunit  (registerunit),
        .writeaddr     (writeaddr),
        .enablewrite   (enablewrite)
    );

    always #5 clock = ~clock;

    // Compare an observed {pending,unit,row} against the expected value.
    task automatic check_entry(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %b_%b_%b expected %b_%b_%b", tag,
                     obs[7], obs[6:5], obs[4:0], exp[7], exp[6:5], exp[4:0]);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] addr, input logic [1:0] unit);
        enablewrite  = 1'b1;
        writeaddr    = addr;
        registerunit = unit;
    endtask

    function automatic logic [7:0] port_a();
        return {ass_pending_a, ass_unit_a, ass_row_a};
    endfunction

    function automatic logic [7:0] port_b();
        return {ass_pending_b, ass_unit_b, ass_row_b};
    endfunction

    initial begin
        reset = 1'b1; enablewrite = 1'b0; writeaddr = 5'd0; registerunit = 2'd0;
        ass_addr_a = 5'd0; ass_addr_b = 5'd0;
        step();
        reset = 1'b0;

        // Reset: every address reads zero on both ports
        for (int i = 0; i < 32; i++) begin
            ass_addr_a = 5'(i);
            ass_addr_b = 5'(31 - i);
            #1;
            check_entry("reset_a", port_a(), 8'b0_00_00000);
            check_entry("reset_b", port_b(), 8'b0_00_00000);
        end

        // Single issue r4 unit1, no bypass before the edge
        ass_addr_a = 5'd4;
        issue(5'd4, 2'd1);
        #1;
        check_entry("no_bypass", port_a(), 8'b0_00_00000);
        step(); enablewrite = 1'b0; #1;
        check_entry("single_n0", port_a(), 8'b1_01_00100);
        step(); check_entry("single_n1", port_a(), 8'b1_01_00010);
        step(); check_entry("single_n2", port_a(), 8'b1_01_00001);
        step(); check_entry("single_clr", port_a(), 8'b0_00_00000);

        // Overwrite r7: unit3 then unit0 two edges later
        ass_addr_a = 5'd7;
        issue(5'd7, 2'd3);
        step(); enablewrite = 1'b0; #1;
        check_entry("ovw_u3", port_a(), 8'b1_11_10000);
        step(); check_entry("ovw_shift", port_a(), 8'b1_11_01000);
        issue(5'd7, 2'd0);
        step(); enablewrite = 1'b0; #1;
        check_entry("ovw_u0", port_a(), 8'b1_00_00001);
        step(); check_entry("ovw_clr", port_a(), 8'b0_00_00000);

        // Issue on the clearing edge of r5
        ass_addr_a = 5'd5;
        issue(5'd5, 2'd0);
        step(); check_entry("clr_u0", port_a(), 8'b1_00_00001);
        issue(5'd5, 2'd2);
        step(); enablewrite = 1'b0; #1;
        check_entry("clr_reissue", port_a(), 8'b1_10_01000);
        step(); check_entry("clr_shift", port_a(), 8'b1_10_00100);

        // Dual ports and register 0
        ass_addr_a = 5'd3; ass_addr_b = 5'd0;
        issue(5'd3, 2'd1);
        step();
        issue(5'd0, 2'd2);
        step(); enablewrite = 1'b0; #1;
        check_entry("dual_a_r3", port_a(), 8'b1_01_00010);
        check_entry("dual_b_r0", port_b(), 8'b0_00_00000);
        ass_addr_b = 5'd3; #1;
        check_entry("dual_same", port_b(), 8'b1_01_00010);

        // Held enablewrite keeps re-issuing r12
        ass_addr_a = 5'd12;
        issue(5'd12, 2'd2);
        step(); step(); step();
        check_entry("held_issue", port_a(), 8'b1_10_01000);
        enablewrite = 1'b0;
        step(); check_entry("held_release", port_a(), 8'b1_10_00100);

        // Reset mid-operation overrides a concurrent write
        ass_addr_a = 5'd9; ass_addr_b = 5'd10;
        issue(5'd9, 2'd3);
        step(); enablewrite = 1'b0;
        step(); step();
        check_entry("mid_r9_pre", port_a(), 8'b1_11_00100);
        reset = 1'b1;
        issue(5'd10, 2'd0);
        step(); reset = 1'b0; enablewrite = 1'b0; #1;
        check_entry("mid_r9", port_a(), 8'b0_00_00000);
        check_entry("mid_r10", port_b(), 8'b0_00_00000);
        ass_addr_a = 5'd12; #1;
        check_entry("mid_r12", port_a(), 8'b0_00_00000);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
